// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with open-drain line control.
// Optional watchdog abort is built in when PS2_TX_TIMEOUT_EN is defined.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int INH_W = ($clog2(INHIBIT_CYCLES + 1) > 13) ? $clog2(INHIBIT_CYCLES + 1) : 13;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t           state;
    logic [1:0]       clk_sync;
    logic [1:0]       data_sync;
    logic             prev_sync_clk;
    logic             sync_clk;
    logic             sync_data;
    logic             clk_fall;
    logic [9:0]       shreg;
    logic [3:0]       bitcnt;
    logic [INH_W-1:0] inh_cnt;
    logic             ack_err_r;

    assign sync_clk  = clk_sync[1];
    assign sync_data = data_sync[1];
    assign clk_fall  = prev_sync_clk & ~sync_clk;

    // Idle-high reset values keep a reset from looking like a device clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync      <= 2'b11;
            data_sync     <= 2'b11;
            prev_sync_clk <= 1'b1;
        end else begin
            clk_sync      <= {clk_sync[0], ps2_clk};
            data_sync     <= {data_sync[0], ps2_data};
            prev_sync_clk <= sync_clk;
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_active;
    logic            wd_expire;

    assign wd_active = (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);
    assign wd_expire = wd_active && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            ack_err     <= 1'b0;
            ack_err_r   <= 1'b0;
            shreg       <= '0;
            bitcnt      <= '0;
            inh_cnt     <= '0;
`ifdef PS2_TX_TIMEOUT_EN
            wd_cnt      <= '0;
            timeout     <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            ack_err <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        shreg       <= {1'b1, ~^tx_data, tx_data};
                        inh_cnt     <= '0;
                        state       <= INHIBIT;
                        tx_ready    <= 1'b0;
                        busy        <= 1'b1;
                        ps2_clk_oe  <= 1'b1;
                        ps2_data_oe <= 1'b0;
                    end
                end
                INHIBIT: begin
                    if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                        state       <= REQ;
                        ps2_data_oe <= 1'b1;
                    end else begin
                        inh_cnt <= inh_cnt + INH_W'(1);
                    end
                end
                REQ: begin
                    state      <= SHIFT;
                    ps2_clk_oe <= 1'b0;
                    bitcnt     <= '0;
`ifdef PS2_TX_TIMEOUT_EN
                    wd_cnt     <= '0;
`endif
                end
                // The start bit stays on the line until the first fall; each fall then presents the next bit.
                SHIFT: begin
                    if (clk_fall) begin
                        ps2_data_oe <= ~shreg[0];
                        shreg       <= {1'b0, shreg[9:1]};
                        bitcnt      <= bitcnt + 4'd1;
                        if (bitcnt == 4'd9) begin
                            state <= ACK;
                        end
                    end
                end
                ACK: begin
                    ps2_data_oe <= 1'b0;
                    if (clk_fall) begin
                        ack_err_r <= sync_data;
                        bitcnt    <= bitcnt + 4'd1;
                        state     <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (sync_clk && sync_data) begin
                        done     <= 1'b1;
                        ack_err  <= ack_err_r;
                        state    <= IDLE;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    tx_ready    <= 1'b1;
                    busy        <= 1'b0;
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                end
            endcase
`ifdef PS2_TX_TIMEOUT_EN
            if (wd_active && (wd_cnt != WD_W'(TIMEOUT_CYCLES))) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            // Abort wins over any frame progress made in the same cycle.
            if (wd_expire) begin
                state       <= IDLE;
                tx_ready    <= 1'b1;
                busy        <= 1'b0;
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                done        <= 1'b0;
                ack_err     <= 1'b0;
                timeout     <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device on open-drain lines, checked
// against a frame model built from byte popcount.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INHIBIT = 20;
    localparam int TIMEOUT = 2000;
    localparam int HALF    = 20;

    typedef struct {
        logic [7:0]  data;
        bit          give_ack;
        logic [10:0] exp_frame;
        bit          exp_ack_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout;
    logic       dev_clk_lo = 1'b0;
    logic       dev_data_lo = 1'b0;
    logic       ps2_clk;
    logic       ps2_data;

    assign ps2_clk  = ~(ps2_clk_oe | dev_clk_lo);
    assign ps2_data = ~(ps2_data_oe | dev_data_lo);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .ack_err    (ack_err),
        .timeout    (timeout)
    );

    always #10 clk = ~clk;

    int   check_cnt = 0;
    int   pass_cnt = 0;
    int   cyc = 0;
    int   oe_run = 0;
    int   last_oe_run = 0;
    int   done_cnt = 0;
    int   timeout_cnt = 0;
    int   overlap_cnt = 0;
    int   accept_cnt = 0;
    int   shift_entry_cyc = 0;
    int   timeout_cyc = 0;
    logic prev_clk_oe = 1'b0;
    logic last_ack_err = 1'b0;

    // Passive observer: run lengths, pulse counts and handshake invariants.
    always @(negedge clk) begin
        cyc++;
        if (ps2_clk_oe) begin
            oe_run++;
        end else if (oe_run != 0) begin
            last_oe_run = oe_run;
            oe_run = 0;
        end
        if (prev_clk_oe && !ps2_clk_oe) shift_entry_cyc = cyc;
        prev_clk_oe = ps2_clk_oe;
        if (done) begin
            done_cnt++;
            last_ack_err = ack_err;
        end
        if (timeout) begin
            timeout_cnt++;
            timeout_cyc = cyc;
        end
        if (tx_ready && busy) overlap_cnt++;
        if (tx_ready && tx_valid && !reset) accept_cnt++;
    end

    function automatic logic [10:0] model_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, ((ones % 2) == 0), d, 1'b0};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (tx_ready && n < 10);
        tx_valid = 1'b0;
        checkOutput("accept_handshake", {tx_ready, busy}, 2'b01);
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
        @(negedge clk);
    endtask

    // Device side: waits for request-to-send, then clocks 11 bits sampling data before each rise.
    task automatic device_frame(input bit give_ack, input int stall_after, input int stall_cycles,
                                input bit quit_after_stall, input int reset_fall,
                                output logic [10:0] rx, output int stall_bad);
        int n = 0;
        rx = '0;
        stall_bad = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rts_seen", n < 200, 1);
        if (n >= 200) return;
        rx[0] = ps2_data;
        repeat (10) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            repeat (HALF) @(negedge clk);
            dev_clk_lo = 1'b1;
            if (k == reset_fall) return;
            repeat (HALF) @(negedge clk);
            if (k <= 10) rx[k] = ps2_data;
            dev_clk_lo = 1'b0;
            if (k == 10) dev_data_lo = give_ack;
            if (k == 11) dev_data_lo = 1'b0;
            if (k == stall_after) begin
                for (int s = 0; s < stall_cycles; s++) begin
                    @(negedge clk);
                    if (busy !== 1'b1 || timeout !== 1'b0) stall_bad++;
                end
                if (quit_after_stall) return;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL global_time_limit: got expired, expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        vec_t        vecs[10];
        logic [10:0] rx;
        logic [7:0]  r;
        int          bad;
        int          d0;
        int          t0;
        int          a0;
        int          n;

        vecs[0] = '{8'hED, 1'b1, model_frame(8'hED), 1'b0};
        vecs[1] = '{8'h01, 1'b0, model_frame(8'h01), 1'b1};
        vecs[2] = '{8'h00, 1'b1, model_frame(8'h00), 1'b0};
        vecs[3] = '{8'h80, 1'b0, model_frame(8'h80), 1'b1};
        vecs[4] = '{8'hA5, 1'b1, model_frame(8'hA5), 1'b0};
        vecs[5] = '{8'hFF, 1'b1, model_frame(8'hFF), 1'b0};
        for (int i = 6; i < 10; i++) begin
            r = 8'($urandom_range(255));
            vecs[i].data        = r;
            vecs[i].give_ack    = bit'($urandom_range(1));
            vecs[i].exp_frame   = model_frame(r);
            vecs[i].exp_ack_err = !vecs[i].give_ack;
        end

        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, ack_err, timeout}, 7'b1000000);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("idle_outputs", {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, ack_err, timeout}, 7'b1000000);

        for (int i = 0; i < 10; i++) begin
            d0 = done_cnt;
            applyStimulus(vecs[i].data);
            device_frame(vecs[i].give_ack, 0, 0, 1'b0, 0, rx, bad);
            wait_done(d0, 60);
            checkOutput($sformatf("frame_%0d_bits", i), rx, vecs[i].exp_frame);
            checkOutput($sformatf("frame_%0d_done", i), done_cnt - d0, 1);
            checkOutput($sformatf("frame_%0d_ack_err", i), last_ack_err, vecs[i].exp_ack_err);
            checkOutput($sformatf("frame_%0d_clk_oe_len", i), last_oe_run, INHIBIT + 1);
            repeat (5) @(negedge clk);
        end

        // tx_valid held across two commands: the second is captured only once the first is done.
        d0 = done_cnt;
        a0 = accept_cnt;
        @(negedge clk);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_ready && n < 10);
        tx_data = 8'hF4;
        device_frame(1'b1, 0, 0, 1'b0, 0, rx, bad);
        checkOutput("b2b_first_bits", rx, model_frame(8'hFF));
        checkOutput("b2b_no_early_accept", accept_cnt - a0, 1);
        wait_done(d0, 60);
        tx_valid = 1'b0;
        checkOutput("b2b_second_accept", accept_cnt - a0, 2);
        device_frame(1'b1, 0, 0, 1'b0, 0, rx, bad);
        wait_done(d0 + 1, 60);
        checkOutput("b2b_second_bits", rx, model_frame(8'hF4));
        checkOutput("b2b_done_count", done_cnt - d0, 2);
        repeat (5) @(negedge clk);

        // Reset in the middle of a frame, then a clean frame afterwards.
        d0 = done_cnt;
        t0 = timeout_cnt;
        applyStimulus(8'hAA);
        device_frame(1'b1, 0, 0, 1'b0, 5, rx, bad);
        checkOutput("midframe_bits", rx[4:0], model_frame(8'hAA) & 11'h01F);
        repeat (4) @(negedge clk);
        checkOutput("midframe_data_oe", ps2_data_oe, 1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("reset_release", {ps2_clk_oe, ps2_data_oe, tx_ready, busy}, 4'b0010);
        reset = 1'b0;
        dev_clk_lo = 1'b0;
        repeat (100) @(negedge clk);
        checkOutput("reset_no_done", done_cnt - d0, 0);
        checkOutput("reset_no_timeout", timeout_cnt - t0, 0);
        applyStimulus(8'h55);
        device_frame(1'b1, 0, 0, 1'b0, 0, rx, bad);
        wait_done(d0, 60);
        checkOutput("after_reset_bits", rx, model_frame(8'h55));
        checkOutput("after_reset_done", done_cnt - d0, 1);
        checkOutput("after_reset_ack_err", last_ack_err, 0);
        repeat (5) @(negedge clk);

`ifdef PS2_TX_TIMEOUT_EN
        d0 = done_cnt;
        t0 = timeout_cnt;
        applyStimulus(8'h3C);
        device_frame(1'b1, 3, 0, 1'b1, 0, rx, bad);
        for (int i = 0; i < TIMEOUT + 500 && timeout_cnt == t0; i++) @(posedge clk);
        checkOutput("timeout_pulses", timeout_cnt - t0, 1);
        checkOutput("timeout_latency", timeout_cyc - shift_entry_cyc, TIMEOUT);
        @(negedge clk);
        checkOutput("timeout_release", {ps2_clk_oe, ps2_data_oe, tx_ready, busy, timeout}, 5'b00100);
        checkOutput("timeout_no_done", done_cnt - d0, 0);
        repeat (50) @(negedge clk);
        applyStimulus(8'h3C);
        device_frame(1'b1, 0, 0, 1'b0, 0, rx, bad);
        wait_done(d0, 60);
        checkOutput("post_timeout_bits", rx, model_frame(8'h3C));
        checkOutput("post_timeout_done", done_cnt - d0, 1);
`else
        d0 = done_cnt;
        applyStimulus(8'h3C);
        device_frame(1'b1, 3, 5000, 1'b0, 0, rx, bad);
        wait_done(d0, 60);
        checkOutput("stall_busy_no_timeout", bad, 0);
        checkOutput("stall_frame_bits", rx, model_frame(8'h3C));
        checkOutput("stall_done", done_cnt - d0, 1);
        checkOutput("stall_ack_err", last_ack_err, 0);
        checkOutput("timeout_never", timeout_cnt, 0);
`endif

        checkOutput("ready_busy_overlap", overlap_cnt, 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
